lvda_pio_arbiter: RTL
=====================

# lvda_pio_arbiter

Shares the single LVDC→LVDA process-I/O (PIO) serial channel between up to NREQ on-chip requesters (telemetry readout, discrete-output driver, interrupt service and similar). It grants requesters round-robin, then sequences one complete PIO transaction:

- address phase
- 26-bit full-duplex serial data phase, strobed by the bit-time tick
- acknowledge wait, with timeout

It sits between the requesters and the address, PIOV, serial-data and DATAV pins of the LVDC/LVDA interface.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WORD_W, 26, PIO data word width; bits numbered [26:1], MSB first on the wire
- ADDR_W, 9, PIO address width (A1V..A9V)
- ACK_TIMEOUT, 64, bit_ticks to wait for DATAV before flagging an error

Ports:
- SIM_CLK  in  1  sole clock; all logic on rising edge
- SIM_RST  in  1  reset, synchronous, active-high
- bit_tick  in  1  one-cycle serial bit-time strobe
- req  in  NREQ  request per requester; held high until its done pulse
- req_rd  in  NREQ  1 = read transaction, 0 = write
- req_addr  in  NREQ*ADDR_W  per-requester PIO address, requester i at slice i
- req_wdata  in  NREQ*WORD_W  per-requester write word
- done  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
- rsp_rdata  out  WORD_W  read word; valid with done, held until the next done
- rsp_err  out  1  ack timeout flag; valid with done, held until the next done
- busy  out  1  high in every state except IDLE
- A  out  ADDR_W  PIO address lines, bits [9:1]
- PIOV  out  1  PIO-valid strobe
- SDO  out  1  serial data to adapter
- SDI  in  1  serial data from adapter
- DATAV  in  1  adapter acknowledge

## Operation
FSM states and transitions:
- IDLE → ARB when any req bit is high.
- ARB (1 cycle): round-robin pick.
  - Search starts at last_gnt+1, modulo NREQ.
  - Latch index, addr, rd, and wdata; wdata is forced to 0 for reads.
  - Go to ADDR.
- ADDR: A = latched addr, PIOV = 1. On bit_tick: bitcnt ← 26, go to SHIFT.
- SHIFT: A and PIOV remain held. SDO = sreg[26].
  - On each bit_tick, rdata ← {rdata[25:1], SDI}, sreg shifts left, bitcnt decrements.
  - The tick that brings bitcnt to 0 moves to WAIT_ACK.
- WAIT_ACK: PIOV = 0, A = 0, SDO = 0.
  - DATAV high → DONE, err = 0.
  - Otherwise count bit_ticks; on reaching ACK_TIMEOUT → DONE, err = 1.
- DONE (1 cycle):
  - done[idx] = 1.
  - rsp_rdata = captured rdata, or 0 for writes.
  - rsp_err = err.
  - last_gnt ← idx.
  - Go to IDLE.

Rules:
- Only the current-state register qualifies bit_tick. A tick in the cycle a state is entered belongs to the previous state and is not consumed by the new one.
- DATAV is checked before the tick counter. DATAV high in the same cycle as the timeout tick gives err = 0.
- A requester dropping req mid-transaction does not abort it; done still pulses.
- Requests arriving during a transaction wait for the next ARB.
- Reset (any state, mid-transaction included):
  - FSM → IDLE, last_gnt ← NREQ-1, so requester 0 wins first.
  - All outputs 0: A, PIOV, SDO, done, rsp_rdata, rsp_err, busy.
  - No done pulse for the aborted transaction.

## Timing
- Request to ARB: 1 cycle. ARB to ADDR: 1 cycle.
- Address phase lasts until the first bit_tick seen in ADDR.
- Data phase is exactly 26 ticks. PIOV is high from ADDR entry to the cycle after the 26th tick.
- DONE follows DATAV (or the timeout) by 1 cycle. IDLE follows DONE by 1 cycle.
- Back-to-back: the earliest next ARB is 2 cycles after DONE (DONE → IDLE → ARB).
- Minimum transaction with no waits: 1 + 1 + tick + 26 ticks + ack + 1 cycles.

## Structure
- Package lvdc_pio_pkg holds:
  - the FSM state enum: IDLE, ARB, ADDR, SHIFT, WAIT_ACK, DONE
  - constants PIO_WORD_W = 26, PIO_ADDR_W = 9
  - the bit-counter width
- One sub-module, lvdc_rr_arbiter: parameterized NREQ round-robin picker, combinational, taking req and last_gnt and producing a one-hot grant and its index.
- Shift register, counters and FSM live in the top module.

## Test plan
- Single write: req[0], addr 9'h1A5, wdata 26'h2AAAAAA, DATAV 2 ticks after the 26th tick.
  - SDO alternates 1,0,… over 26 ticks; A = 1A5 throughout.
  - done[0] pulses once; rsp_rdata = 0; rsp_err = 0.
- Read: req[2] with req_rd, SDI driven 26'h0000001 MSB first, DATAV immediate.
  - rsp_rdata = 26'h0000001; SDO stays 0.
- Fairness: req = 4'b1111 held continuously.
  - Grants in order 0,1,2,3,0.
  - After reset mid-sequence, the next grant is 0.
- Timeout: DATAV never asserted.
  - done pulses on the cycle after the 64th tick in WAIT_ACK; rsp_err = 1.
  - Same-cycle DATAV with the 64th tick gives rsp_err = 0.
- Reset mid-SHIFT after 10 ticks.
  - Next cycle: PIOV = 0, busy = 0, no done pulse.
  - A subsequent transaction completes normally.
- Tick alignment: bit_tick asserted in the cycle ADDR is entered.
  - That tick is ignored; the address phase lasts until the next tick.

Source files
------------

// File: rtl/lvda_pio_arbiter_pkg.sv
// Shared definitions for the LVDC->LVDA PIO channel arbiter.
package lvdc_pio_pkg;

    localparam int PIO_WORD_W = 26;
    localparam int PIO_ADDR_W = 9;
    localparam int PIO_BITCNT_W = $clog2(PIO_WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        SHIFT,
        WAIT_ACK,
        DONE
    } pio_state_e;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lvda_pio_arbiter_if.sv
// Requester-side bus of the PIO arbiter: per-requester request vectors and
// the shared completion/response signals.
interface lvda_pio_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int WORD_W = lvdc_pio_pkg::PIO_WORD_W,
    parameter int ADDR_W = lvdc_pio_pkg::PIO_ADDR_W
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_rd;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*WORD_W-1:0] req_wdata;
    logic [NREQ-1:0]        done;
    logic [WORD_W-1:0]      rsp_rdata;
    logic                   rsp_err;

    // Requesters drive the request side and observe completions.
    modport master (
        output req, req_rd, req_addr, req_wdata,
        input  done, rsp_rdata, rsp_err
    );

    // The arbiter consumes requests and returns completions.
    modport slave (
        input  req, req_rd, req_addr, req_wdata,
        output done, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lvda_pio_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past the last
// granted requester and wraps modulo NREQ.
module lvdc_rr_arbiter
    import lvdc_pio_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    // Walk candidates from farthest to nearest so the nearest active one wins.
    always_comb begin
        int sum;
        logic [IDX_W-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = 0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sum  = int'(last_gnt) + k;
            cand = IDX_W'(sum % NREQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lvda_pio_arbiter.sv
// Round-robin arbiter and transaction sequencer for the single LVDC->LVDA
// PIO serial channel: address phase, full-duplex serial data phase and
// acknowledge wait with timeout.
module lvda_pio_arbiter
    import lvdc_pio_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int WORD_W      = PIO_WORD_W,
    parameter int ADDR_W      = PIO_ADDR_W,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              bit_tick,
    lvda_pio_arbiter_if.slave bus,
    output logic              busy,
    output logic [ADDR_W-1:0] A,
    output logic              PIOV,
    output logic              SDO,
    input  logic              SDI,
    input  logic              DATAV
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    pio_state_e              state;
    logic [IDX_W-1:0]        last_gnt;
    logic [IDX_W-1:0]        idx_q;
    logic [NREQ-1:0]         gnt_q;
    logic                    rd_q;
    logic [WORD_W-1:0]       sreg;
    logic [WORD_W-1:0]       rdata;
    logic [PIO_BITCNT_W-1:0] bitcnt;
    logic [TO_W-1:0]         tocnt;
    logic [NREQ-1:0]         done_q;
    logic [WORD_W-1:0]       rdata_out;
    logic                    err_out;

    logic [NREQ-1:0]   gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_wdata;
    logic              sel_rd;

    lvdc_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req      (bus.req),
        .last_gnt (last_gnt),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_vld  (gnt_vld)
    );

    // Mux the winning requester's address, direction and write word.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*WORD_W +: WORD_W];
                sel_rd    = bus.req_rd[i];
            end
        end
    end

    // Transaction FSM; every pin-facing output is registered here. Datapath
    // registers (sreg, rdata, rd_q) are only meaningful once loaded in ARB,
    // so they are left out of reset.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state     <= IDLE;
            last_gnt  <= IDX_W'(NREQ - 1);
            idx_q     <= '0;
            gnt_q     <= '0;
            bitcnt    <= '0;
            tocnt     <= '0;
            busy      <= 1'b0;
            A         <= '0;
            PIOV      <= 1'b0;
            SDO       <= 1'b0;
            done_q    <= '0;
            rdata_out <= '0;
            err_out   <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    // A request that vanished since IDLE leaves nothing to serve.
                    if (gnt_vld) begin
                        gnt_q <= gnt;
                        idx_q <= gnt_idx;
                        rd_q  <= sel_rd;
                        sreg  <= sel_rd ? '0 : sel_wdata;
                        A     <= sel_addr;
                        PIOV  <= 1'b1;
                        state <= ADDR;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ADDR: begin
                    if (bit_tick) begin
                        bitcnt <= PIO_BITCNT_W'(WORD_W);
                        SDO    <= sreg[WORD_W-1];
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_tick) begin
                        rdata  <= {rdata[WORD_W-2:0], SDI};
                        sreg   <= {sreg[WORD_W-2:0], 1'b0};
                        bitcnt <= bitcnt - 1'b1;
                        if (bitcnt == PIO_BITCNT_W'(1)) begin
                            A     <= '0;
                            PIOV  <= 1'b0;
                            SDO   <= 1'b0;
                            tocnt <= '0;
                            state <= WAIT_ACK;
                        end else begin
                            SDO <= sreg[WORD_W-2];
                        end
                    end
                end
                WAIT_ACK: begin
                    // DATAV takes priority over a coincident timeout tick.
                    if (DATAV) begin
                        done_q    <= gnt_q;
                        rdata_out <= rd_q ? rdata : '0;
                        err_out   <= 1'b0;
                        state     <= DONE;
                    end else if (bit_tick) begin
                        if (tocnt == TO_W'(ACK_TIMEOUT - 1)) begin
                            done_q    <= gnt_q;
                            rdata_out <= rd_q ? rdata : '0;
                            err_out   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            tocnt <= tocnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    last_gnt <= idx_q;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.rsp_rdata = rdata_out;
    assign bus.rsp_err   = err_out;

endmodule
